// File: rtl/alkqseq.sv
// Q register and MUL/DIV step sequencer for the DC615 ALK slice.
// Holds Q, performs sized shifts via the pad-routing boundary bits, and counts iterations.
module alkqseq (
  input  logic        clk_h,
  input  logic        rst_l,
  input  logic [1:0]  dsize_h,
  input  logic        q_load_h,
  input  logic [31:0] q_d_h,
  input  logic        dq_q_shl_l,
  input  logic        dq_q_shr_l,
  input  logic        alpctl_mul_l,
  input  logic        alpctl_div_l,
  input  logic        alpctl_rem_l,
  input  logic        alushf_force_sout0_h,
  input  logic        step_start_h,
  input  logic        alu_sout_h,
  input  logic        alu_cout_h,
  input  logic        q_shl_in_h,
  input  logic        q_shr_in_h,
  output logic [31:0] q_h,
  output logic        q_sin_h,
  output logic        q_lsb_h,
  output logic        q_msb_h,
  output logic        step_busy_h,
  output logic        step_done_h,
  output logic [5:0]  step_count_h
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] q_q, q_d;
  logic [5:0]  count_q, count_d;
  logic        done_q, done_d;

  logic        mulOp, divOp, remOp, startOk, lastStep;
  logic [5:0]  width;
  logic [31:0] sizeMask, qLeft, qRight;
  logic        qMsb;

  assign mulOp    = ~alpctl_mul_l;
  assign divOp    = ~alpctl_div_l;
  assign remOp    = ~alpctl_rem_l;
  assign startOk  = step_start_h & (mulOp | divOp) & ~q_load_h;
  assign lastStep = (state_q == RUN) & (count_q <= 6'd1);

  // Operand size decode: bits above the active width never move on a shift.
  always_comb begin
    width    = 6'd32;
    sizeMask = 32'hFFFF_FFFF;
    qRight   = {q_shr_in_h, q_q[31:1]};
    qMsb     = q_q[31];
    case (dsize_h)
      2'b00: begin
        width    = 6'd8;
        sizeMask = 32'h0000_00FF;
        qRight   = {q_q[31:8], q_shr_in_h, q_q[7:1]};
        qMsb     = q_q[7];
      end
      2'b01: begin
        width    = 6'd16;
        sizeMask = 32'h0000_FFFF;
        qRight   = {q_q[31:16], q_shr_in_h, q_q[15:1]};
        qMsb     = q_q[15];
      end
      default: ;
    endcase
    qLeft = ({q_q[30:0], q_shl_in_h} & sizeMask) | (q_q & ~sizeMask);
  end

  always_ff @(posedge clk_h or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (startOk) state_d = RUN;
      RUN: begin
        if (q_load_h)      state_d = IDLE;
        else if (startOk)  state_d = RUN;
        else if (lastStep) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load or a (re)start edge never shifts; only an uninterrupted final step pulses done.
  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (q_load_h) begin
      q_d     = q_d_h;
      count_d = 6'd0;
    end else if (startOk) begin
      count_d = width;
    end else if (state_q == RUN) begin
      if (mulOp)      q_d = qRight;
      else if (divOp) q_d = qLeft;
      count_d = (count_q == 6'd0) ? 6'd0 : count_q - 6'd1;
      done_d  = lastStep;
    end else if (!dq_q_shl_l) begin
      q_d = qLeft;
    end else if (!dq_q_shr_l) begin
      q_d = qRight;
    end
  end

  always_ff @(posedge clk_h or negedge rst_l) begin
    if (!rst_l) begin
      q_q     <= 32'd0;
      count_q <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    q_h          = q_q;
    q_lsb_h      = q_q[0];
    q_msb_h      = qMsb;
    step_busy_h  = (state_q == RUN);
    step_done_h  = done_q;
    step_count_h = count_q;
    if (alushf_force_sout0_h || remOp) q_sin_h = 1'b0;
    else if (divOp)                    q_sin_h = alu_cout_h;
    else                               q_sin_h = alu_sout_h;
  end

endmodule

// File: tb/tb_alkqseq.sv
// Self-checking bench for alkqseq: table-driven sized shifts plus hand-written
// MUL/DIV sequences, abort, restart and asynchronous reset cases.
module tb_alkqseq;

  logic        clk_h = 1'b0;
  logic        rst_l;
  logic [1:0]  dsize_h;
  logic        q_load_h;
  logic [31:0] q_d_h;
  logic        dq_q_shl_l, dq_q_shr_l;
  logic        alpctl_mul_l, alpctl_div_l, alpctl_rem_l;
  logic        alushf_force_sout0_h, step_start_h;
  logic        alu_sout_h, alu_cout_h, q_shl_in_h, q_shr_in_h;
  logic [31:0] q_h;
  logic        q_sin_h, q_lsb_h, q_msb_h, step_busy_h, step_done_h;
  logic [5:0]  step_count_h;

  alkqseq dut (
    .clk_h(clk_h), .rst_l(rst_l), .dsize_h(dsize_h), .q_load_h(q_load_h), .q_d_h(q_d_h),
    .dq_q_shl_l(dq_q_shl_l), .dq_q_shr_l(dq_q_shr_l), .alpctl_mul_l(alpctl_mul_l),
    .alpctl_div_l(alpctl_div_l), .alpctl_rem_l(alpctl_rem_l),
    .alushf_force_sout0_h(alushf_force_sout0_h), .step_start_h(step_start_h),
    .alu_sout_h(alu_sout_h), .alu_cout_h(alu_cout_h), .q_shl_in_h(q_shl_in_h),
    .q_shr_in_h(q_shr_in_h), .q_h(q_h), .q_sin_h(q_sin_h), .q_lsb_h(q_lsb_h),
    .q_msb_h(q_msb_h), .step_busy_h(step_busy_h), .step_done_h(step_done_h),
    .step_count_h(step_count_h)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    logic [31:0] init;
    logic [1:0]  dsize;
    logic        shlL;
    logic        shrL;
    logic        shlIn;
    logic        shrIn;
    logic [31:0] expQ;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] expQueue[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          doneCount;

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic msbOf(input logic [31:0] v, input logic [1:0] sz);
    if (sz == 2'b00) return v[7];
    if (sz == 2'b01) return v[15];
    return v[31];
  endfunction

  // Load the initial Q, then drive one idle DQ shift and queue the expected result.
  task automatic applyStimulus(input vec_t v);
    q_load_h = 1'b1;
    q_d_h    = v.init;
    tick();
    q_load_h   = 1'b0;
    dsize_h    = v.dsize;
    dq_q_shl_l = v.shlL;
    dq_q_shr_l = v.shrL;
    q_shl_in_h = v.shlIn;
    q_shr_in_h = v.shrIn;
    expQueue.push_back(v.expQ);
  endtask

  task automatic loadQ(input logic [31:0] val);
    q_load_h = 1'b1;
    q_d_h    = val;
    tick();
    q_load_h = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] expQ;
    vecs[0] = '{32'hA5A5_A5A5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5_A54B};
    vecs[1] = '{32'h8000_0001, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000};
    vecs[2] = '{32'h8000_0001, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_8000};
    vecs[3] = '{32'h1234_5678, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_ACF0};
    vecs[4] = '{32'h1234_5678, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_56BC};
    vecs[5] = '{32'hFFFF_FFFF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[6] = '{32'h0000_00F0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00E0};
    vecs[7] = '{32'hDEAD_BEEF, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[8] = '{32'h0000_0001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000};
    vecs[9] = '{32'h0000_00FF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00FF};

    rst_l = 1'b0;
    dsize_h = 2'b00; q_load_h = 1'b0; q_d_h = 32'd0;
    dq_q_shl_l = 1'b1; dq_q_shr_l = 1'b1;
    alpctl_mul_l = 1'b1; alpctl_div_l = 1'b1; alpctl_rem_l = 1'b1;
    alushf_force_sout0_h = 1'b0; step_start_h = 1'b0;
    alu_sout_h = 1'b0; alu_cout_h = 1'b0; q_shl_in_h = 1'b0; q_shr_in_h = 1'b0;
    #12;
    checkOutput("reset q", q_h, 32'd0);
    checkOutput("reset busy", {31'd0, step_busy_h}, 32'd0);
    checkOutput("reset done", {31'd0, step_done_h}, 32'd0);
    checkOutput("reset count", {26'd0, step_count_h}, 32'd0);
    rst_l = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick();
      dq_q_shl_l = 1'b1;
      dq_q_shr_l = 1'b1;
      if (expQueue.size() == 0) begin
        checkOutput($sformatf("vec%0d queue empty", i), 32'd1, 32'd0);
      end else begin
        expQ = expQueue.pop_front();
        checkOutput($sformatf("vec%0d q", i), q_h, expQ);
        checkOutput($sformatf("vec%0d lsb", i), {31'd0, q_lsb_h}, {31'd0, expQ[0]});
        checkOutput($sformatf("vec%0d msb", i), {31'd0, q_msb_h}, {31'd0, msbOf(expQ, vecs[i].dsize)});
      end
    end

    // Start without MUL/DIV must be ignored.
    dsize_h = 2'b00; step_start_h = 1'b1;
    tick();
    step_start_h = 1'b0;
    checkOutput("ignored start busy", {31'd0, step_busy_h}, 32'd0);
    checkOutput("ignored start count", {26'd0, step_count_h}, 32'd0);

    // Word MUL: sixteen right shifts filling the low half with ones.
    loadQ(32'h1234_0000);
    dsize_h = 2'b01; alpctl_mul_l = 1'b0; q_shr_in_h = 1'b1; q_shl_in_h = 1'b0;
    step_start_h = 1'b1;
    tick();
    step_start_h = 1'b0;
    checkOutput("mul start count", {26'd0, step_count_h}, 32'd16);
    checkOutput("mul start busy", {31'd0, step_busy_h}, 32'd1);
    checkOutput("mul start q", q_h, 32'h1234_0000);
    doneCount = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      doneCount += int'(step_done_h);
      checkOutput($sformatf("mul count %0d", i), {26'd0, step_count_h}, 32'(16 - i));
      checkOutput($sformatf("mul busy %0d", i), {31'd0, step_busy_h}, (i < 16) ? 32'd1 : 32'd0);
    end
    checkOutput("mul done pulse", {31'd0, step_done_h}, 32'd1);
    checkOutput("mul done count", 32'(doneCount), 32'd1);
    checkOutput("mul final q", q_h, 32'h1234_FFFF);
    tick();
    checkOutput("mul done clears", {31'd0, step_done_h}, 32'd0);
    alpctl_mul_l = 1'b1;

    // Byte DIV with a restart at count 3.
    loadQ(32'h0000_0001);
    dsize_h = 2'b00; alpctl_div_l = 1'b0; alu_cout_h = 1'b1; alu_sout_h = 1'b0;
    q_shl_in_h = 1'b1; q_shr_in_h = 1'b0;
    #1;
    checkOutput("div sin cout1", {31'd0, q_sin_h}, 32'd1);
    step_start_h = 1'b1;
    tick();
    step_start_h = 1'b0;
    checkOutput("div start count", {26'd0, step_count_h}, 32'd8);
    doneCount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      doneCount += int'(step_done_h);
    end
    checkOutput("div count before restart", {26'd0, step_count_h}, 32'd3);
    checkOutput("div q before restart", q_h, 32'h0000_003F);
    step_start_h = 1'b1;
    tick();
    step_start_h = 1'b0;
    checkOutput("div restart count", {26'd0, step_count_h}, 32'd8);
    checkOutput("div restart q", q_h, 32'h0000_003F);
    checkOutput("div restart busy", {31'd0, step_busy_h}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      doneCount += int'(step_done_h);
    end
    checkOutput("div final q", q_h, 32'h0000_00FF);
    checkOutput("div final busy", {31'd0, step_busy_h}, 32'd0);
    checkOutput("div done count", 32'(doneCount), 32'd1);
    tick();
    checkOutput("div done clears", {31'd0, step_done_h}, 32'd0);
    alu_cout_h = 1'b0;
    #1;
    checkOutput("div sin cout0", {31'd0, q_sin_h}, 32'd0);

    // q_sin priority: force, then REM, then DIV, then sout.
    alu_cout_h = 1'b1; alu_sout_h = 1'b0; alushf_force_sout0_h = 1'b1;
    #1;
    checkOutput("sin force over div", {31'd0, q_sin_h}, 32'd0);
    alushf_force_sout0_h = 1'b0; alpctl_div_l = 1'b1; alu_sout_h = 1'b1;
    #1;
    checkOutput("sin sout", {31'd0, q_sin_h}, 32'd1);
    alpctl_rem_l = 1'b0;
    #1;
    checkOutput("sin rem", {31'd0, q_sin_h}, 32'd0);
    alpctl_rem_l = 1'b1; alu_sout_h = 1'b0; alu_cout_h = 1'b0;

    // Load during a long MUL aborts it without a done pulse.
    dsize_h = 2'b10; alpctl_mul_l = 1'b0; step_start_h = 1'b1;
    tick();
    step_start_h = 1'b0;
    checkOutput("abort start count", {26'd0, step_count_h}, 32'd32);
    tick(); tick(); tick();
    checkOutput("abort mid count", {26'd0, step_count_h}, 32'd29);
    q_load_h = 1'b1; q_d_h = 32'hCAFE_F00D;
    tick();
    q_load_h = 1'b0;
    checkOutput("abort q", q_h, 32'hCAFE_F00D);
    checkOutput("abort busy", {31'd0, step_busy_h}, 32'd0);
    checkOutput("abort count", {26'd0, step_count_h}, 32'd0);
    tick();
    checkOutput("abort no done", {31'd0, step_done_h}, 32'd0);
    checkOutput("abort q holds", q_h, 32'hCAFE_F00D);

    // Asynchronous reset mid-run clears everything immediately.
    dsize_h = 2'b00; step_start_h = 1'b1;
    tick();
    step_start_h = 1'b0;
    tick(); tick();
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("async rst q", q_h, 32'd0);
    checkOutput("async rst busy", {31'd0, step_busy_h}, 32'd0);
    checkOutput("async rst count", {26'd0, step_count_h}, 32'd0);
    checkOutput("async rst done", {31'd0, step_done_h}, 32'd0);
    checkOutput("async rst sin", {31'd0, q_sin_h}, 32'd0);
    alpctl_mul_l = 1'b1;
    #1;
    rst_l = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      doneCount += int'(step_done_h);
    end
    checkOutput("post rst busy", {31'd0, step_busy_h}, 32'd0);
    checkOutput("post rst q", q_h, 32'd0);
    checkOutput("post rst no done", 32'(doneCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alkqseq.md
# alkqseq

Q register and multiply/divide step sequencer for the DC615 ALK slice of the DPM datapath. It sits directly beside the Q shift-in/out routing stage. It holds the 32-bit Q register and performs sized left/right shifts using the boundary bits that the routing stage recovers from the Q_SIO pads. It generates `q_sin_h`, the bit that the routing stage drives back onto the pads. It also runs the fixed-length iteration count for MUL/DIV microinstructions.

## Interface
- Parameters: none.
- `clk_h  in  1` — datapath clock; all state changes on the rising edge.
- `rst_l  in  1` — asynchronous, active-low reset.
- `dsize_h  in  2` — operand size: 00 = byte (W=8), 01 = word (W=16), 1x = long (W=32).
- `q_load_h  in  1` — load Q from `q_d_h`.
- `q_d_h  in  32` — Q load data (ALU result bus).
- `dq_q_shl_l  in  1` — DQ field: shift Q left, active low.
- `dq_q_shr_l  in  1` — DQ field: shift Q right, active low.
- `alpctl_mul_l  in  1` — ALPCTL MUL decode, active low.
- `alpctl_div_l  in  1` — ALPCTL DIV decode, active low.
- `alpctl_rem_l  in  1` — ALPCTL REM decode, active low.
- `alushf_force_sout0_h  in  1` — force shift-out bit to 0.
- `step_start_h  in  1` — begin a MUL/DIV iteration sequence.
- `alu_sout_h  in  1` — ALU shifter shift-out bit.
- `alu_cout_h  in  1` — ALU carry out; this is the quotient bit.
- `q_shl_in_h  in  1` — bit entering Q[0] on a left shift, from the routing stage.
- `q_shr_in_h  in  1` — bit entering Q[W-1] on a right shift, from the routing stage.
- `q_h  out  32` — Q register contents.
- `q_sin_h  out  1` — shift-in bit presented to the routing stage.
- `q_lsb_h  out  1` — Q[0]; multiplier bit.
- `q_msb_h  out  1` — Q[W-1].
- `step_busy_h  out  1` — iteration sequence in progress.
- `step_done_h  out  1` — one-cycle pulse after the final iteration.
- `step_count_h  out  6` — remaining iterations.

## Operation
- **Reset (async, `rst_l`=0):**
  - `q_h`=0.
  - `step_count_h`=0.
  - `step_busy_h`=0.
  - `step_done_h`=0.
  - The combinational outputs follow from this state.
- **`q_sin_h` selection (combinational), in priority order:**
  1. `alushf_force_sout0_h` → 0.
  2. REM → 0.
  3. DIV → `alu_cout_h`.
  4. Otherwise → `alu_sout_h`.
- **Q update per edge, in priority order:**
  1. `q_load_h`: Q ← `q_d_h`, all 32 bits. This also aborts any sequence: busy and count are cleared and no done pulse is produced.
  2. Busy with MUL: right shift.
  3. Busy with DIV: left shift.
  4. Not busy, `dq_q_shl_l`=0: left shift.
  5. Not busy, `dq_q_shr_l`=0: right shift.
  6. Otherwise: hold.
  - If both DQ shifts are asserted while idle, left wins.
- **Sized shifts:**
  - Left: Q[W-1:1] ← Q[W-2:0], Q[0] ← `q_shl_in_h`.
  - Right: Q[W-2:0] ← Q[W-1:1], Q[W-1] ← `q_shr_in_h`.
  - Bits Q[31:W] hold unchanged in both cases.
- **Sequencer states:**
  - **IDLE → RUN:** `step_start_h` with MUL or DIV asserted (and `q_load_h` low). Count ← W; no shift on that edge.
  - `step_start_h` without MUL/DIV is ignored.
  - **RUN:** each edge shifts Q and decrements the count.
  - **RUN → IDLE:** on the edge where the count goes 1→0. `step_done_h` is high for exactly the following cycle.
  - `step_start_h` during RUN restarts: count ← W on that edge, no shift on that edge, no done pulse for the aborted run.
- **Size changes:** `dsize_h` is sampled every edge. A change during RUN takes effect immediately for the shift width. The count is not reloaded.

## Timing
- Q load latency is 1 edge.
- A sequence started at edge E0 produces shifts at edges E1..EW. `step_busy_h` is high from after E0 to after EW. `step_done_h` is high in the cycle after EW.
- Cycles from start to done:
  - Byte: 9.
  - Word: 17.
  - Long: 33.
- `q_lsb_h`, `q_msb_h` and `q_sin_h` are combinational from the current state and inputs, valid within the same cycle. The routing stage's pad loop closes within one cycle.
- An asynchronous reset during RUN ends the sequence immediately with no done pulse.

## Test plan
- **Reset:** assert `rst_l`=0 mid-RUN → all outputs 0 immediately; after release, idle with Q=0.
- **Sized left shift:** load Q=0xA5A5_A5A5; byte SHL with `q_shl_in_h`=1 → Q=0xA5A5_A54B.
- **Long right shift:** load 0x8000_0001; long SHR with `q_shr_in_h`=0 → Q=0x4000_0000.
- **Word MUL sequence:** word MUL start, `q_shr_in_h`=1 → busy for 16 cycles, count 16→0, done pulse in cycle 17, Q[15:0]=0xFFFF, Q[31:16] unchanged.
- **Byte DIV with restart:** byte DIV start; restart at count=3 → count reloads to 8, only one done pulse occurs, 8 shifts follow the restart; `q_sin_h` tracks `alu_cout_h`.
- **Priority and abort:** `q_load_h` during RUN → Q=`q_d_h`, busy=0, no done pulse. `alushf_force_sout0_h`=1 with DIV and `alu_cout_h`=1 → `q_sin_h`=0.
